// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared types and defaults for the fetch sequencing controller
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_FLUSH,
        ST_HALT,
        ST_FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    localparam int DEF_RESET_HOLD   = 2;
    localparam int DEF_FLUSH_CYCLES = 2;
    localparam int DEF_ADDR_MAX     = 1023;

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC/fetch sequencing: boot hold, redirect bubbles, stall replay, debug halt, address fault
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int RESET_HOLD   = DEF_RESET_HOLD,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int ADDR_MAX     = DEF_ADDR_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] pc_nxt,
    input  logic        hazard_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        halt_req,
    input  logic        step_req,
    output logic [31:0] in_pc,
    output logic [31:0] in_alu,
    output logic        sel_pc,
    output logic        stall,
    output logic        flush,
    output logic        halted,
    output logic        addr_fault
);

    localparam int CNT_MAX = (RESET_HOLD > FLUSH_CYCLES) ? RESET_HOLD : FLUSH_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_MAX);

    fetch_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic replay_q;
    logic step_pend, step_pend_nxt;
    logic fault_q, fault_nxt;
    logic halted_q;
    logic redirect;
    logic fault_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_BOOT;
            cnt       <= CNT_W'(RESET_HOLD - 1);
            replay_q  <= 1'b1;
            step_pend <= 1'b0;
            fault_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            replay_q  <= stall;
            step_pend <= step_pend_nxt;
            fault_q   <= fault_nxt;
            halted_q  <= (state_nxt == ST_HALT) || (state_nxt == ST_FAULT);
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        step_pend_nxt = step_pend;
        fault_nxt     = fault_q;
        stall         = 1'b1;
        redirect      = 1'b0;
        fault_hit     = 1'b0;
        in_pc         = replay_q ? pc : pc_nxt;

        case (state)
            ST_BOOT: begin
                if (cnt == '0) state_nxt = ST_RUN;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_RUN: begin
                if (br_taken) begin
                    redirect = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_nxt   = CNT_W'(FLUSH_CYCLES - 2);
                        state_nxt = ST_FLUSH;
                    end
                end else if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (!hazard_stall) begin
                    stall = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (cnt == '0) state_nxt = ST_RUN;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            ST_HALT: begin
                if (step_req) step_pend_nxt = 1'b1;
                if (br_taken) begin
                    redirect = 1'b1;
                end else if (!halt_req) begin
                    state_nxt     = ST_RUN;
                    step_pend_nxt = 1'b0;
                end else if (step_pend && !hazard_stall) begin
                    stall         = 1'b0;
                    step_pend_nxt = 1'b0;
                end
            end
            ST_FAULT: begin
            end
            default: state_nxt = ST_BOOT;
        endcase

        // An illegal fetch or redirect target is squashed and locks the block up until reset.
        if ((redirect && (br_target > ADDR_LIMIT)) || (!stall && (in_pc > ADDR_LIMIT))) begin
            fault_hit     = 1'b1;
            redirect      = 1'b0;
            stall         = 1'b1;
            fault_nxt     = 1'b1;
            step_pend_nxt = 1'b0;
            state_nxt     = ST_FAULT;
        end

        in_alu = br_target;
        sel_pc = redirect;
        flush  = redirect | fault_hit;

        if (rst) begin
            stall  = 1'b1;
            sel_pc = 1'b0;
            flush  = 1'b0;
            in_pc  = pc;
        end
    end

    assign halted     = halted_q & ~rst;
    assign addr_fault = fault_q & ~rst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven bench for fetch_ctrl with directed multi-cycle sequences
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc, pc_nxt, br_target;
    logic        hazard_stall, br_taken, halt_req, step_req;
    logic [31:0] in_pc, in_alu;
    logic        sel_pc, stall, flush, halted, addr_fault;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_HOLD  (DEF_RESET_HOLD),
        .FLUSH_CYCLES(DEF_FLUSH_CYCLES),
        .ADDR_MAX    (DEF_ADDR_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_nxt      (pc_nxt),
        .hazard_stall(hazard_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .in_pc       (in_pc),
        .in_alu      (in_alu),
        .sel_pc      (sel_pc),
        .stall       (stall),
        .flush       (flush),
        .halted      (halted),
        .addr_fault  (addr_fault)
    );

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        haz;
        logic        br;
        logic [31:0] tgt;
        logic        halt;
        logic        step;
        logic [31:0] e_pc;
        logic        e_sel;
        logic        e_stall;
        logic        e_flush;
        logic        e_halted;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic r, input logic [31:0] p, input logic hz, input logic b,
                       input logic [31:0] t, input logic hl, input logic st,
                       input logic [31:0] epc, input logic esel, input logic estall,
                       input logic eflush, input logic ehalt, input logic efault);
        vec_t v;
        v.rst = r; v.pc = p; v.haz = hz; v.br = b; v.tgt = t; v.halt = hl; v.step = st;
        v.e_pc = epc; v.e_sel = esel; v.e_stall = estall; v.e_flush = eflush;
        v.e_halted = ehalt; v.e_fault = efault;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst          = v.rst;
        pc           = v.pc;
        pc_nxt       = v.pc + 32'd1;
        hazard_stall = v.haz;
        br_taken     = v.br;
        br_target    = v.tgt;
        halt_req     = v.halt;
        step_req     = v.step;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        chk("in_pc", idx, in_pc, v.e_pc);
        chk("in_alu", idx, in_alu, v.tgt);
        chk("sel_pc", idx, 32'(sel_pc), 32'(v.e_sel));
        chk("stall", idx, 32'(stall), 32'(v.e_stall));
        chk("flush", idx, 32'(flush), 32'(v.e_flush));
        chk("halted", idx, 32'(halted), 32'(v.e_halted));
        chk("addr_fault", idx, 32'(addr_fault), 32'(v.e_fault));
    endtask

    task automatic cycle(input vec_t v, input int idx);
        drive(v);
        @(negedge clk);
        check_vec(v, idx);
        @(posedge clk);
        #1;
    endtask

    task automatic seq(input logic [31:0] p, input logic hz, input logic [31:0] epc,
                       input logic estall, input int idx);
        vec_t v;
        v = '{1'b0, p, hz, 1'b0, 32'd0, 1'b0, 1'b0, epc, 1'b0, estall, 1'b0, 1'b0, 1'b0};
        cycle(v, idx);
    endtask

    initial begin
        // rst pc haz br tgt halt step | in_pc sel stall flush halted fault
        add(1, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 0, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  1,      0, 0, 0, 0, 0);
        add(0, 1,      0, 0, 0,      0, 0,  2,      0, 0, 0, 0, 0);
        add(0, 2,      0, 0, 0,      0, 0,  3,      0, 0, 0, 0, 0);
        add(0, 3,      0, 0, 0,      0, 0,  4,      0, 0, 0, 0, 0);
        add(0, 4,      0, 0, 0,      0, 0,  5,      0, 0, 0, 0, 0);
        add(0, 5,      1, 0, 0,      0, 0,  6,      0, 1, 0, 0, 0);
        add(0, 6,      0, 0, 0,      0, 0,  6,      0, 0, 0, 0, 0);
        add(0, 6,      0, 0, 0,      0, 0,  7,      0, 0, 0, 0, 0);
        add(0, 7,      0, 1, 'h40,   0, 0,  8,      1, 1, 1, 0, 0);
        add(0, 'h40,   0, 1, 'h80,   0, 0,  'h40,   0, 1, 0, 0, 0);
        add(0, 'h40,   0, 0, 0,      0, 0,  'h40,   0, 0, 0, 0, 0);
        add(0, 'h40,   0, 0, 0,      0, 0,  'h41,   0, 0, 0, 0, 0);
        add(0, 'h41,   0, 0, 0,      1, 0,  'h42,   0, 1, 0, 0, 0);
        add(0, 'h42,   0, 0, 0,      1, 0,  'h42,   0, 1, 0, 1, 0);
        add(0, 'h42,   0, 0, 0,      1, 1,  'h42,   0, 1, 0, 1, 0);
        add(0, 'h42,   0, 0, 0,      1, 0,  'h42,   0, 0, 0, 1, 0);
        add(0, 'h42,   0, 0, 0,      1, 0,  'h43,   0, 1, 0, 1, 0);
        add(0, 'h43,   0, 0, 0,      1, 0,  'h43,   0, 1, 0, 1, 0);
        add(0, 'h43,   0, 0, 0,      0, 0,  'h43,   0, 1, 0, 1, 0);
        add(0, 'h43,   0, 0, 0,      0, 0,  'h43,   0, 0, 0, 0, 0);
        add(0, 'h43,   0, 0, 0,      0, 0,  'h44,   0, 0, 0, 0, 0);
        add(0, 'h44,   0, 1, 'h10,   1, 0,  'h45,   1, 1, 1, 0, 0);
        add(0, 'h10,   0, 0, 0,      1, 0,  'h10,   0, 1, 0, 0, 0);
        add(0, 'h10,   0, 0, 0,      1, 0,  'h10,   0, 1, 0, 0, 0);
        add(0, 'h10,   0, 0, 0,      1, 0,  'h10,   0, 1, 0, 1, 0);
        add(0, 'h10,   0, 1, 'h20,   1, 0,  'h10,   1, 1, 1, 1, 0);
        add(0, 'h20,   0, 0, 0,      0, 0,  'h20,   0, 1, 0, 1, 0);
        add(0, 'h20,   0, 0, 0,      0, 0,  'h20,   0, 0, 0, 0, 0);
        add(0, 'h20,   0, 1, 'h30,   0, 0,  'h21,   1, 1, 1, 0, 0);
        add(1, 'h30,   0, 0, 0,      0, 0,  'h30,   0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 0, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  1,      0, 0, 0, 0, 0);
        add(0, 1,      0, 1, 2000,   0, 0,  2,      0, 1, 1, 0, 0);
        add(0, 1,      0, 1, 5,      1, 0,  1,      0, 1, 0, 1, 1);
        add(0, 1,      0, 0, 0,      0, 0,  1,      0, 1, 0, 1, 1);
        add(1, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);
        add(0, 0,      0, 0, 0,      0, 0,  0,      0, 0, 0, 0, 0);
        add(0, 1022,   0, 0, 0,      0, 0,  1023,   0, 0, 0, 0, 0);
        add(0, 1023,   0, 0, 0,      0, 0,  1024,   0, 1, 1, 0, 0);
        add(0, 1023,   0, 0, 0,      0, 0,  1023,   0, 1, 0, 1, 1);
        add(1, 0,      0, 0, 0,      0, 0,  0,      0, 1, 0, 0, 0);

        foreach (vecs[i]) cycle(vecs[i], i);

        // Boot hold measured directly, with a bounded wait for the first unstalled cycle.
        begin
            int n_stall;
            bit seen;
            n_stall = 0;
            seen    = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                drive('{1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
                @(negedge clk);
                if (stall === 1'b0) begin
                    seen = 1'b1;
                    chk("boot_first_pc", 100, in_pc, 32'd0);
                end else begin
                    n_stall++;
                end
                @(posedge clk);
                #1;
            end
            chk("boot_seen", 101, 32'(seen), 32'd1);
            chk("boot_hold", 102, 32'(n_stall), 32'(DEF_RESET_HOLD));
        end

        // Two back-to-back hazard cycles: address 1 replayed until the decode stage frees up.
        seq(0, 1, 1, 1, 110);
        seq(1, 1, 1, 1, 111);
        seq(1, 0, 1, 0, 112);
        seq(1, 0, 2, 0, 113);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
